// File: rtl/axis_image_pipe_mc_pkg.sv
// Shared types and helpers for the multi-channel image pipe.
package axis_image_pipe_mc_pkg;

    typedef enum logic [1:0] {
        ST_SET  = 2'd0,
        ST_ONES = 2'd1,
        ST_PASS = 2'd2
    } state_e;

    // Header field offsets within the stream-0 header beat; each field is one byte wide.
    localparam int unsigned HDR_IS_MAX  = 0;
    localparam int unsigned HDR_KH      = 8;
    localparam int unsigned HDR_NACT    = 16;
    localparam int unsigned HDR_FIELD_W = 8;

    function automatic int unsigned bits_kh_f(input int unsigned kh_max);
        return (kh_max <= 2) ? 1 : $clog2(kh_max);
    endfunction

    function automatic int unsigned bits_n_f(input int unsigned n_in);
        return (n_in <= 2) ? 1 : $clog2(n_in);
    endfunction

    function automatic int unsigned ue_f(input int unsigned units, input int unsigned kh_max);
        return units + kh_max - 1;
    endfunction

endpackage

// File: rtl/axis_image_pipe_mc_join.sv
// N-stream valid/ready join with active mask, generated-beat injection and a registered output slot.
module axis_join_n #(
    parameter int unsigned N      = 4,
    parameter int unsigned BEAT_W = 32,
    parameter int unsigned USER_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                join_en,
    input  logic [N-1:0]        act,
    input  logic [N-1:0]        s_valid,
    input  logic [N-1:0]        s_last,
    input  logic [N*BEAT_W-1:0] s_data,
    output logic [N-1:0]        s_ready,
    input  logic                gen_en,
    input  logic [BEAT_W-1:0]   gen_beat,
    input  logic [USER_W-1:0]   user,
    output logic                load,
    output logic                join_fire,
    output logic                gen_fire,
    output logic                last_err,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [N*BEAT_W-1:0] m_data,
    output logic [USER_W-1:0]   m_user
);

    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [N*BEAT_W-1:0] data_q, data_d;
    logic [USER_W-1:0]   user_q, user_d;
    logic [N-1:0]        ok;

    // Handshake: a stream is "ok" if valid or not in the active set; each active stream
    // is ready only when every other active stream is valid, so no stream is taken alone.
    always_comb begin
        ok        = s_valid | ~act;
        load      = !valid_q || m_ready;
        join_fire = join_en && load && (&ok);
        gen_fire  = gen_en && load;
        for (int unsigned k = 0; k < N; k++) begin
            s_ready[k] = join_en && load && act[k] && (&(ok | (N'(1) << k)));
        end
        last_err = join_fire && (|(act & (s_last ^ {N{s_last[0]}})));
    end

    // Next slot contents: joined beat, generated beat, or emptied when drained.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        user_d  = user_q;
        if (load) begin
            valid_d = join_fire || gen_fire;
            last_d  = 1'b0;
            if (join_fire) begin
                last_d = s_last[0];
                user_d = user;
                for (int unsigned k = 0; k < N; k++) begin
                    data_d[k*BEAT_W +: BEAT_W] = act[k] ? s_data[k*BEAT_W +: BEAT_W]
                                                        : s_data[0 +: BEAT_W];
                end
            end else if (gen_fire) begin
                user_d = user;
                data_d = {N{gen_beat}};
            end
        end
    end

    // Output slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            user_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            user_q  <= user_d;
        end
    end

    assign m_valid = valid_q;
    assign m_last  = last_q;
    assign m_data  = data_q;
    assign m_user  = user_q;

endmodule

// File: rtl/axis_image_pipe_mc.sv
// Multi-channel image pipe: header parse, constant config beats, then N-stream joined pixel data.
module axis_image_pipe_mc
    import axis_image_pipe_mc_pkg::*;
#(
    parameter  int unsigned UNITS        = 2,
    parameter  int unsigned WORD_WIDTH   = 8,
    parameter  int unsigned KERNEL_H_MAX = 3,
    parameter  int unsigned N_IN         = 4,
    parameter  int unsigned CFG_BASE     = 13,
    parameter  int unsigned CFG_PER_KH   = 4,
    parameter  int unsigned ONE_VALUE    = 1,
    parameter  int unsigned BITS_CFG     = 8,
    localparam int unsigned UE           = ue_f(UNITS, KERNEL_H_MAX),
    localparam int unsigned BITS_KH      = bits_kh_f(KERNEL_H_MAX),
    localparam int unsigned BITS_N       = bits_n_f(N_IN),
    localparam int unsigned BEAT_W       = UE * WORD_WIDTH,
    localparam int unsigned USER_W       = BITS_KH + 1 + BITS_N
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [N_IN-1:0]        s_axis_tvalid,
    output logic [N_IN-1:0]        s_axis_tready,
    input  logic [N_IN-1:0]        s_axis_tlast,
    input  logic [N_IN*BEAT_W-1:0] s_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [N_IN*BEAT_W-1:0] m_axis_tdata,
    output logic [USER_W-1:0]      m_axis_tuser,
    output logic [1:0]             err,
    input  logic                   err_clear
);

    localparam logic [HDR_FIELD_W-1:0] KH_LIM = HDR_FIELD_W'(KERNEL_H_MAX - 1);
    localparam logic [HDR_FIELD_W-1:0] N_LIM  = HDR_FIELD_W'(N_IN - 1);

    state_e               state_q, state_d;
    logic                 is_max_q, is_max_d;
    logic [BITS_KH-1:0]   kh_q, kh_d;
    logic [BITS_N-1:0]    nact_q, nact_d;
    logic [BITS_CFG-1:0]  cnt_q, cnt_d;
    logic [1:0]           err_q, err_d;

    logic [HDR_FIELD_W-1:0] hdr_kh, hdr_nact;
    logic [BITS_CFG-1:0]    beats_last;
    logic [N_IN-1:0]        act, join_rdy;
    logic [BEAT_W-1:0]      ones_beat;
    logic                   load, join_fire, gen_fire, last_err, hdr_fire;

    assign hdr_kh     = s_axis_tdata[HDR_KH +: HDR_FIELD_W];
    assign hdr_nact   = s_axis_tdata[HDR_NACT +: HDR_FIELD_W];
    assign beats_last = BITS_CFG'(CFG_BASE + CFG_PER_KH * 32'(kh_q) - 1);
    assign ones_beat  = {UE{WORD_WIDTH'(ONE_VALUE)}};
    assign hdr_fire   = (state_q == ST_SET) && load && s_axis_tvalid[0];

    // Active-stream mask: streams 0..n_act_1.
    always_comb begin
        for (int unsigned k = 0; k < N_IN; k++) begin
            act[k] = (BITS_N'(k) <= nact_q);
        end
    end

    // Only stream 0 is ready in SET (header); the join owns readiness in PASS.
    always_comb begin
        s_axis_tready = join_rdy;
        if (state_q == ST_SET) begin
            s_axis_tready    = '0;
            s_axis_tready[0] = load;
        end
        if (areset) begin
            s_axis_tready = '0;
        end
    end

    axis_join_n #(
        .N      (N_IN),
        .BEAT_W (BEAT_W),
        .USER_W (USER_W)
    ) u_join (
        .clk       (aclk),
        .rst       (areset),
        .join_en   (state_q == ST_PASS),
        .act       (act),
        .s_valid   (s_axis_tvalid),
        .s_last    (s_axis_tlast),
        .s_data    (s_axis_tdata),
        .s_ready   (join_rdy),
        .gen_en    (state_q == ST_ONES),
        .gen_beat  (ones_beat),
        .user      ({nact_q, is_max_q, kh_q}),
        .load      (load),
        .join_fire (join_fire),
        .gen_fire  (gen_fire),
        .last_err  (last_err),
        .m_valid   (m_axis_tvalid),
        .m_ready   (m_axis_tready),
        .m_last    (m_axis_tlast),
        .m_data    (m_axis_tdata),
        .m_user    (m_axis_tuser)
    );

    // Frame sequencing, header latch with clamping, ones counter and sticky errors.
    always_comb begin
        state_d  = state_q;
        is_max_d = is_max_q;
        kh_d     = kh_q;
        nact_d   = nact_q;
        cnt_d    = cnt_q;
        err_d    = err_clear ? 2'b00 : err_q;
        case (state_q)
            ST_SET: begin
                if (hdr_fire) begin
                    is_max_d = s_axis_tdata[HDR_IS_MAX];
                    kh_d     = (hdr_kh > KH_LIM) ? BITS_KH'(KERNEL_H_MAX - 1) : hdr_kh[BITS_KH-1:0];
                    if (!s_axis_tdata[HDR_IS_MAX]) begin
                        nact_d = '0;
                    end else begin
                        nact_d = (hdr_nact > N_LIM) ? BITS_N'(N_IN - 1) : hdr_nact[BITS_N-1:0];
                    end
                    if ((hdr_kh > KH_LIM) || (hdr_nact > N_LIM) || s_axis_tlast[0]) begin
                        err_d[0] = 1'b1;
                    end
                    if (!s_axis_tlast[0]) begin
                        state_d = ST_ONES;
                    end
                end
            end
            ST_ONES: begin
                if (gen_fire) begin
                    if (cnt_q == beats_last) begin
                        cnt_d   = '0;
                        state_d = ST_PASS;
                    end else begin
                        cnt_d = cnt_q + BITS_CFG'(1);
                    end
                end
            end
            ST_PASS: begin
                if (join_fire && s_axis_tlast[0]) begin
                    state_d = ST_SET;
                end
            end
            default: state_d = ST_SET;
        endcase
        if (last_err) begin
            err_d[1] = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_SET;
            is_max_q <= 1'b0;
            kh_q     <= '0;
            nact_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            is_max_q <= is_max_d;
            kh_q     <= kh_d;
            nact_q   <= nact_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_axis_image_pipe_mc.sv
// Scoreboard bench for axis_image_pipe_mc at N_IN=4, UE=4, 8-bit words.
module tb_axis_image_pipe_mc;

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic [4:0]   user;
    } exp_t;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [3:0]   s_axis_tvalid = '0;
    logic [3:0]   s_axis_tready;
    logic [3:0]   s_axis_tlast = '0;
    logic [127:0] s_axis_tdata = '0;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;
    logic [127:0] m_axis_tdata;
    logic [4:0]   m_axis_tuser;
    logic [1:0]   err;
    logic         err_clear = 1'b0;

    int unsigned  n_checks = 0;
    int unsigned  n_pass = 0;
    int unsigned  beats_seen = 0;
    int unsigned  ready_mode = 0;
    int unsigned  cur_nact = 0;
    logic [4:0]   cur_user = '0;
    logic [127:0] ones_beat;
    exp_t         sb[$];

    axis_image_pipe_mc #(
        .UNITS        (2),
        .WORD_WIDTH   (8),
        .KERNEL_H_MAX (3),
        .N_IN         (4),
        .CFG_BASE     (13),
        .CFG_PER_KH   (4),
        .ONE_VALUE    (1),
        .BITS_CFG     (8)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .err           (err),
        .err_clear     (err_clear)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [127:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] join_exp(input int unsigned n_act, input logic [127:0] d);
        logic [127:0] r;
        for (int unsigned k = 0; k < 4; k++) begin
            r[k*32 +: 32] = (k <= n_act) ? d[k*32 +: 32] : d[31:0];
        end
        return r;
    endfunction

    // Output ready pattern: 0 = always ready, 1 = random 50%, otherwise stalled.
    initial begin
        forever begin
            @(posedge aclk);
            #2;
            case (ready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Output monitor: hold-stability check and scoreboard pop on each accepted beat.
    initial begin
        logic         prev_hold;
        logic [127:0] held;
        exp_t         e;
        prev_hold = 1'b0;
        held = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check_eq("hold_valid", 128'(m_axis_tvalid), 128'(1));
                    check_eq("hold_data", m_axis_tdata, held);
                end
                prev_hold = m_axis_tvalid && !m_axis_tready;
                held = m_axis_tdata;
                if (m_axis_tvalid && m_axis_tready) begin
                    beats_seen++;
                    if (sb.size() == 0) begin
                        check_eq("unexpected_beat", 128'(m_axis_tvalid), 128'(0));
                    end else begin
                        e = sb.pop_front();
                        check_eq("beat_data", m_axis_tdata, e.data);
                        check_eq("beat_last", 128'(m_axis_tlast), 128'(e.last));
                        check_eq("beat_user", 128'(m_axis_tuser), 128'(e.user));
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [3:0] vmask, input logic [3:0] amask,
                             input logic [127:0] data, input logic [3:0] lasts);
        int unsigned n;
        logic hs;
        s_axis_tvalid = vmask;
        s_axis_tdata  = data;
        s_axis_tlast  = lasts;
        n = 0;
        forever begin
            @(negedge aclk);
            if (n == 0) begin
                check_eq("rdy_inactive", 128'(s_axis_tready & ~amask), 128'(0));
            end
            hs = ((s_axis_tready & amask) == amask);
            @(posedge aclk);
            #1;
            if (hs) break;
            n++;
            if (n > 3000) begin
                check_eq("send_timeout", 128'(s_axis_tready), 128'(amask));
                break;
            end
        end
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
    endtask

    function automatic logic [127:0] hdr_beat(input logic im, input int unsigned kh, input int unsigned n);
        logic [127:0] h;
        h = rand_beat();
        h[0]     = im;
        h[15:8]  = 8'(kh);
        h[23:16] = 8'(n);
        return h;
    endfunction

    // Header followed by its expected run of ones beats.
    task automatic run_header(input logic im, input int unsigned kh, input int unsigned n);
        int unsigned ke, ne;
        exp_t e;
        ke = (kh > 2) ? 2 : kh;
        ne = !im ? 0 : ((n > 3) ? 3 : n);
        cur_nact = ne;
        cur_user = {2'(ne), im, 2'(ke)};
        for (int unsigned i = 0; i < 13 + 4 * ke; i++) begin
            e.data = ones_beat;
            e.last = 1'b0;
            e.user = cur_user;
            sb.push_back(e);
        end
        send_beat(4'b0001, 4'b0001, hdr_beat(im, kh, n), 4'b0000);
    endtask

    task automatic send_data(input logic [3:0] vmask, input logic [3:0] lasts);
        logic [3:0]   amask;
        logic [127:0] d;
        exp_t         e;
        for (int unsigned k = 0; k < 4; k++) amask[k] = (k <= cur_nact);
        d = rand_beat();
        e.data = join_exp(cur_nact, d);
        e.last = lasts[0];
        e.user = cur_user;
        sb.push_back(e);
        send_beat(vmask, amask, d, lasts);
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge aclk);
            n++;
        end
        @(posedge aclk);
        #1;
        check_eq(tag, 128'(sb.size()), 128'(0));
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge aclk);
        #1;
        err_clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int unsigned i = 0; i < 16; i++) ones_beat[i*8 +: 8] = 8'h01;

        // Reset values
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_valid", 128'(m_axis_tvalid), 128'(0));
        check_eq("rst_last", 128'(m_axis_tlast), 128'(0));
        check_eq("rst_data", m_axis_tdata, 128'(0));
        check_eq("rst_user", 128'(m_axis_tuser), 128'(0));
        check_eq("rst_err", 128'(err), 128'(0));
        check_eq("rst_tready", 128'(s_axis_tready), 128'(0));
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check_eq("set_tready", 128'(s_axis_tready), 128'(4'b0001));
        @(posedge aclk);
        #1;

        // 3 active streams, kh_1=1 -> 17 ones beats + 3 data beats
        beats_seen = 0;
        run_header(1'b1, 1, 2);
        send_data(4'b0111, 4'b0000);
        send_data(4'b0111, 4'b0000);
        send_data(4'b0111, 4'b0111);
        wait_drain("t1_drain");
        check_eq("t1_beats", 128'(beats_seen), 128'(20));
        check_eq("t1_err", 128'(err), 128'(0));

        // is_max=0 forces a single stream; inactive streams valid but never consumed
        beats_seen = 0;
        run_header(1'b0, 0, 3);
        send_data(4'b1111, 4'b0000);
        send_data(4'b1111, 4'b0000);
        send_data(4'b1111, 4'b0001);
        wait_drain("t2_drain");
        check_eq("t2_beats", 128'(beats_seen), 128'(16));

        // Random backpressure across ones and pass
        beats_seen = 0;
        ready_mode = 1;
        run_header(1'b1, 1, 1);
        for (int unsigned i = 0; i < 4; i++) send_data(4'b0011, (i == 3) ? 4'b0011 : 4'b0000);
        wait_drain("t3_drain");
        check_eq("t3_beats", 128'(beats_seen), 128'(21));
        ready_mode = 0;

        // Early tlast on stream 1: sticky err_tlast, frame ends on stream-0 tlast
        beats_seen = 0;
        run_header(1'b1, 0, 1);
        send_data(4'b0011, 4'b0000);
        send_data(4'b0011, 4'b0010);
        send_data(4'b0011, 4'b0001);
        wait_drain("t4_drain");
        check_eq("t4_beats", 128'(beats_seen), 128'(16));
        check_eq("t4_err", 128'(err), 128'(2'b10));
        repeat (3) @(posedge aclk);
        #1;
        check_eq("t4_err_sticky", 128'(err), 128'(2'b10));
        pulse_clear();
        check_eq("t4_err_clr", 128'(err), 128'(0));

        // Out-of-range header fields clamp and flag; header with tlast is dropped
        beats_seen = 0;
        run_header(1'b1, 3, 7);
        send_data(4'b1111, 4'b0000);
        send_data(4'b1111, 4'b1111);
        wait_drain("t5_drain");
        check_eq("t5_beats", 128'(beats_seen), 128'(23));
        check_eq("t5_err_hdr", 128'(err), 128'(2'b01));
        pulse_clear();
        check_eq("t5_err_clr", 128'(err), 128'(0));
        send_beat(4'b0001, 4'b0001, hdr_beat(1'b1, 1, 1), 4'b0001);
        repeat (20) @(posedge aclk);
        @(negedge aclk);
        check_eq("t5_tl_err", 128'(err), 128'(2'b01));
        check_eq("t5_tl_set", 128'(s_axis_tready), 128'(4'b0001));
        check_eq("t5_tl_beats", 128'(beats_seen), 128'(23));
        @(posedge aclk);
        #1;
        pulse_clear();

        // Reset mid-PASS with a held beat, then a normal frame
        run_header(1'b1, 0, 0);
        wait_drain("t6_ones");
        ready_mode = 2;
        @(posedge aclk);
        #1;
        send_data(4'b0001, 4'b0000);
        s_axis_tvalid = 4'b0001;
        s_axis_tdata  = rand_beat();
        @(posedge aclk);
        #1;
        check_eq("t6_stalled", 128'(m_axis_tvalid), 128'(1));
        areset = 1'b1;
        #1;
        check_eq("t6_rst_valid", 128'(m_axis_tvalid), 128'(0));
        check_eq("t6_rst_data", m_axis_tdata, 128'(0));
        check_eq("t6_rst_tready", 128'(s_axis_tready), 128'(0));
        sb.delete();
        s_axis_tvalid = '0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        ready_mode = 0;
        beats_seen = 0;
        run_header(1'b1, 0, 0);
        send_data(4'b0001, 4'b0001);
        wait_drain("t6_drain");
        check_eq("t6_beats", 128'(beats_seen), 128'(14));
        check_eq("t6_err", 128'(err), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
